branch_target_predictor: RTL and testbench



---
 rtl/branch_target_predictor.sv | 118 +++++++++++
 tb/tb_branch_target_predictor.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Combinational lookup from the IF-stage PC; trained by branches resolving in ME.
module branch_target_predictor #(
    parameter int ENTRIES      = 16,
    parameter int COUNTER_BITS = 2,
    parameter int TAG_WIDTH    = 8,
    parameter int PC_INCREMENT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] lookup_pc,
    output logic        hit,
    output logic        predict_taken,
    output logic [31:0] predict_next_pc,
    input  logic        update_valid,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    input  logic [31:0] update_target,
    input  logic        update_predicted_taken,
    input  logic        flush_all,
    output logic [31:0] update_count,
    output logic [31:0] mispredict_count
);

    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam logic [COUNTER_BITS-1:0] CTR_WT  = COUNTER_BITS'(1) << (COUNTER_BITS - 1);
    localparam logic [COUNTER_BITS-1:0] CTR_WNT = CTR_WT - COUNTER_BITS'(1);

    logic                    valid_q  [ENTRIES];
    logic [TAG_WIDTH-1:0]    tag_q    [ENTRIES];
    logic [31:0]             target_q [ENTRIES];
    logic [COUNTER_BITS-1:0] ctr_q    [ENTRIES];

    logic [31:0] updCount_q, updCount_d;
    logic [31:0] mispCount_q, mispCount_d;

    logic [IDX_BITS-1:0]     lookIdx, updIdx;
    logic [TAG_WIDTH-1:0]    lookTag, updTag;
    logic                    updHit;
    logic [COUNTER_BITS-1:0] updCtr_d;
    logic                    unusedUpdPc;

    assign lookIdx = lookup_pc[IDX_BITS+1:2];
    assign lookTag = lookup_pc[IDX_BITS+TAG_WIDTH+1:IDX_BITS+2];
    assign updIdx  = update_pc[IDX_BITS+1:2];
    assign updTag  = update_pc[IDX_BITS+TAG_WIDTH+1:IDX_BITS+2];

    // Alignment and high PC bits are not part of the index or tag.
    assign unusedUpdPc = ^update_pc;

    assign hit             = valid_q[lookIdx] && (tag_q[lookIdx] == lookTag);
    assign predict_taken   = hit && ctr_q[lookIdx][COUNTER_BITS-1];
    assign predict_next_pc = predict_taken ? target_q[lookIdx]
                                           : lookup_pc + 32'(PC_INCREMENT);

    assign updHit = valid_q[updIdx] && (tag_q[updIdx] == updTag);

    assign update_count     = updCount_q;
    assign mispredict_count = mispCount_q;

    always_comb begin
        updCtr_d = ctr_q[updIdx];
        if (update_taken) begin
            if (ctr_q[updIdx] != '1) begin
                updCtr_d = ctr_q[updIdx] + COUNTER_BITS'(1);
            end
        end else if (ctr_q[updIdx] != '0) begin
            updCtr_d = ctr_q[updIdx] - COUNTER_BITS'(1);
        end

        // Statistics saturate rather than wrap so long runs stay meaningful.
        updCount_d  = updCount_q;
        mispCount_d = mispCount_q;
        if (update_valid) begin
            if (updCount_q != '1) begin
                updCount_d = updCount_q + 32'd1;
            end
            if ((update_taken != update_predicted_taken) && (mispCount_q != '1)) begin
                mispCount_d = mispCount_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WNT;
            end
            updCount_q  <= '0;
            mispCount_q <= '0;
        end else begin
            updCount_q  <= updCount_d;
            mispCount_q <= mispCount_d;
            // A flush wins over any table training in the same cycle.
            if (flush_all) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    valid_q[i] <= 1'b0;
                end
            end else if (update_valid) begin
                if (updHit) begin
                    ctr_q[updIdx] <= updCtr_d;
                    if (update_taken) begin
                        target_q[updIdx] <= update_target;
                    end
                end else if (update_taken) begin
                    valid_q[updIdx]  <= 1'b1;
                    tag_q[updIdx]    <= updTag;
                    target_q[updIdx] <= update_target;
                    ctr_q[updIdx]    <= CTR_WT;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Randomized and directed bench for branch_target_predictor, checked against a
// behavioural BTB model; two instances cover the default and a 64-entry/3-bit build.
module tb_branch_target_predictor;

    logic        clk;
    logic        reset;
    logic [31:0] lookup_pc;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic        update_predicted_taken;
    logic        flush_all;

    logic        hit0, pt0, hit1, pt1;
    logic [31:0] npc0, uc0, mc0, npc1, uc1, mc1;

    int checks = 0;
    int errors = 0;

    branch_target_predictor dut (
        .clk(clk), .reset(reset), .lookup_pc(lookup_pc),
        .hit(hit0), .predict_taken(pt0), .predict_next_pc(npc0),
        .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target), .update_predicted_taken(update_predicted_taken),
        .flush_all(flush_all), .update_count(uc0), .mispredict_count(mc0)
    );

    branch_target_predictor #(.ENTRIES(64), .COUNTER_BITS(3)) dutWide (
        .clk(clk), .reset(reset), .lookup_pc(lookup_pc),
        .hit(hit1), .predict_taken(pt1), .predict_next_pc(npc1),
        .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target), .update_predicted_taken(update_predicted_taken),
        .flush_all(flush_all), .update_count(uc1), .mispredict_count(mc1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: model 0 is 16 entries / 2-bit, model 1 is 64 entries / 3-bit.
    int          mEntries [2] = '{16, 64};
    int          mBits    [2] = '{2, 3};
    bit          mValid   [2][64];
    int unsigned mTag     [2][64];
    logic [31:0] mTarget  [2][64];
    int          mCtr     [2][64];
    longint      mUpd, mMisp;

    function automatic int idxOf(int m, logic [31:0] pc);
        return int'((pc >> 2) % mEntries[m]);
    endfunction

    function automatic int unsigned tagOf(int m, logic [31:0] pc);
        return int'(((pc >> 2) / mEntries[m]) % 256);
    endfunction

    function automatic bit modelHit(int m, logic [31:0] pc);
        return mValid[m][idxOf(m, pc)] && (mTag[m][idxOf(m, pc)] == tagOf(m, pc));
    endfunction

    function automatic bit modelTaken(int m, logic [31:0] pc);
        return modelHit(m, pc) && (mCtr[m][idxOf(m, pc)] >= (1 << (mBits[m] - 1)));
    endfunction

    function automatic logic [31:0] modelNext(int m, logic [31:0] pc);
        return modelTaken(m, pc) ? mTarget[m][idxOf(m, pc)] : pc + 32'd4;
    endfunction

    task automatic modelReset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 64; i++) begin
                mValid[m][i]  = 1'b0;
                mTag[m][i]    = 0;
                mTarget[m][i] = 32'd0;
                mCtr[m][i]    = (1 << (mBits[m] - 1)) - 1;
            end
        end
        mUpd  = 0;
        mMisp = 0;
    endtask

    task automatic modelUpdate();
        int i;
        int maxCtr;
        if (update_valid) begin
            if (mUpd < 64'hFFFF_FFFF) mUpd++;
            if ((update_taken != update_predicted_taken) && (mMisp < 64'hFFFF_FFFF)) mMisp++;
        end
        for (int m = 0; m < 2; m++) begin
            maxCtr = (1 << mBits[m]) - 1;
            i = idxOf(m, update_pc);
            if (flush_all) begin
                for (int k = 0; k < 64; k++) mValid[m][k] = 1'b0;
            end else if (update_valid) begin
                if (modelHit(m, update_pc)) begin
                    if (update_taken) begin
                        if (mCtr[m][i] < maxCtr) mCtr[m][i]++;
                        mTarget[m][i] = update_target;
                    end else if (mCtr[m][i] > 0) begin
                        mCtr[m][i]--;
                    end
                end else if (update_taken) begin
                    mValid[m][i]  = 1'b1;
                    mTag[m][i]    = tagOf(m, update_pc);
                    mTarget[m][i] = update_target;
                    mCtr[m][i]    = 1 << (mBits[m] - 1);
                end
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic compareAll();
        checkOutput("hit16",   32'(hit0), 32'(modelHit(0, lookup_pc)));
        checkOutput("taken16", 32'(pt0),  32'(modelTaken(0, lookup_pc)));
        checkOutput("next16",  npc0,      modelNext(0, lookup_pc));
        checkOutput("upd16",   uc0,       32'(mUpd));
        checkOutput("misp16",  mc0,       32'(mMisp));
        checkOutput("hit64",   32'(hit1), 32'(modelHit(1, lookup_pc)));
        checkOutput("taken64", 32'(pt1),  32'(modelTaken(1, lookup_pc)));
        checkOutput("next64",  npc1,      modelNext(1, lookup_pc));
        checkOutput("upd64",   uc1,       32'(mUpd));
        checkOutput("misp64",  mc1,       32'(mMisp));
    endtask

    // Drive one cycle: check lookup against pre-edge state, then advance the model.
    task automatic applyStimulus(input logic [31:0] lpc, input logic uv, input logic [31:0] upc,
                                 input logic ut, input logic [31:0] utg, input logic upt,
                                 input logic fl);
        @(negedge clk);
        lookup_pc              = lpc;
        update_valid           = uv;
        update_pc              = upc;
        update_taken           = ut;
        update_target          = utg;
        update_predicted_taken = upt;
        flush_all              = fl;
        #1;
        compareAll();
        @(posedge clk);
        modelUpdate();
        #1;
    endtask

    initial begin
        logic [31:0] pc;
        logic [31:0] lpc;
        reset                  = 1'b0;
        lookup_pc              = 32'h0040_0010;
        update_valid           = 1'b0;
        update_pc              = 32'd0;
        update_taken           = 1'b0;
        update_target          = 32'd0;
        update_predicted_taken = 1'b0;
        flush_all              = 1'b0;
        modelReset();

        // Defaults straight out of reset, before any clock edge.
        #3;
        checkOutput("t1_hit",  32'(hit0), 32'd0);
        checkOutput("t1_pt",   32'(pt0),  32'd0);
        checkOutput("t1_next", npc0,      32'h0040_0014);
        checkOutput("t1_upd",  uc0,       32'd0);
        checkOutput("t1_misp", mc0,       32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(32'h0040_0010, 0, 0, 0, 0, 0, 0);

        // Allocation on a taken miss.
        applyStimulus(32'h0040_0010, 1, 32'h0040_0010, 1, 32'h0040_0040, 0, 0);
        checkOutput("t2_hit",  32'(hit0), 32'd1);
        checkOutput("t2_pt",   32'(pt0),  32'd1);
        checkOutput("t2_next", npc0,      32'h0040_0040);
        checkOutput("t2_upd",  uc0,       32'd1);
        checkOutput("t2_misp", mc0,       32'd1);
        checkOutput("t2_pt64", 32'(pt1),  32'd1);

        // Saturation down then up, target rewritten on each taken update.
        applyStimulus(32'h0040_0010, 1, 32'h0040_0010, 0, 32'h0, 1, 0);
        checkOutput("t3_pt_nt1", 32'(pt0), 32'd0);
        applyStimulus(32'h0040_0010, 1, 32'h0040_0010, 0, 32'h0, 0, 0);
        applyStimulus(32'h0040_0010, 1, 32'h0040_0010, 0, 32'h0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(32'h0040_0010, 1, 32'h0040_0010, 1, 32'h0040_0100 + 32'(k * 4), 0, 0);
        end
        checkOutput("t3_pt_sat", 32'(pt0), 32'd1);
        checkOutput("t3_target", npc0,     32'h0040_010C);
        applyStimulus(32'h0040_0020, 1, 32'h0040_0020, 0, 32'h0, 0, 0);
        checkOutput("t3_nt_miss_hit", 32'(hit0), 32'd0);
        checkOutput("t3_nt_miss_upd", uc0,       32'd9);

        // Aliasing into index 4 with a different tag.
        applyStimulus(32'h0040_0050, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_alias_miss", 32'(hit0), 32'd0);
        applyStimulus(32'h0040_0050, 1, 32'h0040_0050, 1, 32'h0040_0100, 1, 0);
        checkOutput("t4_alias_hit",  32'(hit0), 32'd1);
        checkOutput("t4_alias_next", npc0,      32'h0040_0100);
        applyStimulus(32'h0040_0010, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_evicted", 32'(hit0), 32'd0);

        // Flush, then same-cycle lookup/update, then flush racing an update.
        applyStimulus(32'h0040_0010, 0, 0, 0, 0, 0, 1);
        applyStimulus(32'h0040_0010, 1, 32'h0040_0010, 1, 32'h0040_0040, 0, 0);
        checkOutput("t5_visible", 32'(hit0), 32'd1);
        applyStimulus(32'h0040_0010, 1, 32'h0040_0080, 1, 32'h0040_0200, 0, 1);
        checkOutput("t5_flushed", 32'(hit0), 32'd0);
        applyStimulus(32'h0040_0080, 0, 0, 0, 0, 0, 0);

        // Random traffic over a small PC pool to force hits and aliasing.
        for (int n = 0; n < 600; n++) begin
            pc = 32'h0040_0000 + (32'($urandom_range(0, 127)) << 2);
            if ($urandom_range(0, 7) == 0) pc = $urandom & 32'hFFFF_FFFC;
            lpc = ($urandom_range(0, 1) == 1) ? pc
                : 32'h0040_0000 + (32'($urandom_range(0, 127)) << 2);
            applyStimulus(lpc, 1'($urandom_range(0, 3) != 0), pc, 1'($urandom_range(0, 1)),
                          $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 49) == 0));
        end

        // Asynchronous reset between edges with a pending update.
        applyStimulus(32'h0040_0010, 1, 32'h0040_0010, 1, 32'h0040_0040, 1, 0);
        @(negedge clk);
        lookup_pc    = 32'h0040_0010;
        update_valid = 1'b1;
        update_pc    = 32'h0040_0010;
        update_taken = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        checkOutput("t6_hit",    32'(hit0), 32'd0);
        checkOutput("t6_next",   npc0,      32'h0040_0014);
        checkOutput("t6_upd",    uc0,       32'd0);
        checkOutput("t6_misp",   mc0,       32'd0);
        checkOutput("t6_hit64",  32'(hit1), 32'd0);
        modelReset();
        @(posedge clk);
        #1;
        compareAll();
        @(negedge clk);
        reset        = 1'b1;
        update_valid = 1'b0;
        #1;
        compareAll();

        // Rerun allocation after reset on both builds.
        applyStimulus(32'h0040_0010, 1, 32'h0040_0010, 1, 32'h0040_0040, 0, 0);
        checkOutput("t6_realloc_pt64",   32'(pt1), 32'd1);
        checkOutput("t6_realloc_next64", npc1,     32'h0040_0040);
        applyStimulus(32'h0040_0110, 0, 0, 0, 0, 0, 0);
        applyStimulus(32'h0040_0110, 1, 32'h0040_0110, 1, 32'h0040_0300, 1, 0);
        applyStimulus(32'h0040_0010, 0, 0, 0, 0, 0, 0);
        checkOutput("t6_alias64", 32'(hit1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
